// File: rtl/thand.sv
// Dual-rail threshold AND gate with NULL/DATA wavefront handshake.
// Latches a result on complete DATA and releases it on complete NULL.
module thand #(
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a0,
    input  logic             a1,
    input  logic             b0,
    input  logic             b1,
    output logic             r0,
    output logic             r1,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] wave_cnt
);

    typedef enum logic {
        S_NULL = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] raw;
    logic [3:0] ev;

    assign raw = {a1, a0, b1, b0};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ev = raw;
        end else begin : g_sync
            logic [3:0] sr [SYNC_STAGES];

            // Shift raw rails through the synchronizer chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sr[i] <= '0;
                    end
                end else begin
                    sr[0] <= raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign ev = sr[SYNC_STAGES-1];
        end
    endgenerate

    logic ea1, ea0, eb1, eb0;
    logic a_null, b_null, a_data, b_data, bad_code;

    assign {ea1, ea0, eb1, eb0} = ev;
    assign a_null   = ~ea1 & ~ea0;
    assign b_null   = ~eb1 & ~eb0;
    assign a_data   = ea1 ^ ea0;
    assign b_data   = eb1 ^ eb0;
    assign bad_code = (ea1 & ea0) | (eb1 & eb0);

    // Wavefront FSM: latch on full DATA, release on full NULL, freeze on illegal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_NULL;
            r0       <= 1'b0;
            r1       <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wave_cnt <= '0;
        end else begin
            unique case (1'b1)
                bad_code: begin
                    err <= 1'b1;
                end
                (state == S_NULL) && a_data && b_data: begin
                    state <= S_DATA;
                    r1    <= ea1 & eb1;
                    r0    <= ~(ea1 & eb1);
                    done  <= 1'b1;
                end
                (state == S_DATA) && a_null && b_null: begin
                    state    <= S_NULL;
                    r0       <= 1'b0;
                    r1       <= 1'b0;
                    done     <= 1'b0;
                    wave_cnt <= wave_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thand.sv
// Self-checking bench for thand: directed wavefront scenarios plus
// randomized dual-rail traffic against a behavioural model.
module tb_thand;

    logic        clk;
    logic        rst_n;
    logic        a0, a1, b0, b1;
    logic        r0, r1, done, err;
    logic [15:0] wave_cnt;

    int total;
    int bad;

    // model: codes 0=NULL 1=DATA0 2=DATA1 3=ILLEGAL
    bit m_busy;
    bit m_res;
    bit m_err;
    int m_cnt;

    thand #(.SYNC_STAGES(0), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a0       (a0),
        .a1       (a1),
        .b0       (b0),
        .b1       (b1),
        .r0       (r0),
        .r1       (r1),
        .done     (done),
        .err      (err),
        .wave_cnt (wave_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] obs();
        return {r1, r0, done, err, wave_cnt};
    endfunction

    function automatic logic [19:0] mexp();
        logic o1, o0;
        o1 = m_busy && m_res;
        o0 = m_busy && !m_res;
        return {o1, o0, o1 | o0, m_err, 16'(m_cnt)};
    endfunction

    function automatic logic [19:0] lit(bit e1, bit e0, bit e, int c);
        return {e1, e0, e1 | e0, e, 16'(c)};
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_res  = 0;
        m_err  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic [1:0] ca, input logic [1:0] cb);
        if (ca == 2'd3 || cb == 2'd3) begin
            m_err = 1;
        end else if (!m_busy && ca != 0 && cb != 0) begin
            m_busy = 1;
            m_res  = (ca == 2'd2) && (cb == 2'd2);
        end else if (m_busy && ca == 0 && cb == 0) begin
            m_busy = 0;
            m_cnt  = (m_cnt + 1) % 65536;
        end
    endtask

    // codes given as {x1,x0}
    task automatic drive(input logic [1:0] ca, input logic [1:0] cb);
        {a1, a0} = ca;
        {b1, b0} = cb;
        @(posedge clk);
        #1;
        model_step(ca, cb);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (obs() !== lit(0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs(), lit(0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 2'b00);
            total++;
            if (obs() !== lit(0, 0, 0, 0)) begin
                bad++;
                $display("FAIL idle_null[%0d] got=%h want=%h", i, obs(),
                         lit(0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_handshake();
        drive(2'b01, 2'b00);
        total++;
        if (obs() !== lit(0, 0, 0, 0)) begin
            bad++;
            $display("FAIL half_data got=%h want=%h", obs(), lit(0, 0, 0, 0));
        end
        drive(2'b01, 2'b01);
        total++;
        if (obs() !== lit(0, 1, 0, 0)) begin
            bad++;
            $display("FAIL full_data got=%h want=%h", obs(), lit(0, 1, 0, 0));
        end
    endtask

    task automatic test_partial_null();
        drive(2'b00, 2'b01);
        total++;
        if (obs() !== lit(0, 1, 0, 0)) begin
            bad++;
            $display("FAIL partial_hold got=%h want=%h", obs(), lit(0, 1, 0, 0));
        end
        drive(2'b10, 2'b10);
        total++;
        if (obs() !== lit(0, 1, 0, 0)) begin
            bad++;
            $display("FAIL no_data_to_data got=%h want=%h", obs(),
                     lit(0, 1, 0, 0));
        end
        drive(2'b00, 2'b00);
        total++;
        if (obs() !== lit(0, 0, 0, 1)) begin
            bad++;
            $display("FAIL full_null got=%h want=%h", obs(), lit(0, 0, 0, 1));
        end
    endtask

    task automatic test_waves();
        drive(2'b01, 2'b10);
        total++;
        if (obs() !== lit(0, 1, 0, 1)) begin
            bad++;
            $display("FAIL d0_d1 got=%h want=%h", obs(), lit(0, 1, 0, 1));
        end
        drive(2'b00, 2'b00);
        total++;
        if (obs() !== lit(0, 0, 0, 2)) begin
            bad++;
            $display("FAIL wave2 got=%h want=%h", obs(), lit(0, 0, 0, 2));
        end
        drive(2'b10, 2'b10);
        total++;
        if (obs() !== lit(1, 0, 0, 2)) begin
            bad++;
            $display("FAIL d1_d1 got=%h want=%h", obs(), lit(1, 0, 0, 2));
        end
    endtask

    task automatic test_illegal();
        drive(2'b00, 2'b00);
        drive(2'b11, 2'b01);
        total++;
        if (obs() !== lit(0, 0, 1, 3)) begin
            bad++;
            $display("FAIL illegal_set got=%h want=%h", obs(), lit(0, 0, 1, 3));
        end
        drive(2'b01, 2'b01);
        drive(2'b00, 2'b00);
        total++;
        if (obs() !== lit(0, 0, 1, 4)) begin
            bad++;
            $display("FAIL err_sticky got=%h want=%h", obs(), lit(0, 0, 1, 4));
        end
        drive(2'b10, 2'b10);
        drive(2'b10, 2'b11);
        total++;
        if (obs() !== lit(1, 0, 1, 4)) begin
            bad++;
            $display("FAIL illegal_hold got=%h want=%h", obs(), lit(1, 0, 1, 4));
        end
        pulse_reset();
        total++;
        if (obs() !== lit(0, 0, 0, 0)) begin
            bad++;
            $display("FAIL err_clear got=%h want=%h", obs(), lit(0, 0, 0, 0));
        end
    endtask

    task automatic test_async_reset();
        drive(2'b10, 2'b10);
        drive(2'b00, 2'b00);
        drive(2'b10, 2'b10);
        total++;
        if (obs() !== lit(1, 0, 0, 1)) begin
            bad++;
            $display("FAIL pre_reset got=%h want=%h", obs(), lit(1, 0, 0, 1));
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== lit(0, 0, 0, 0)) begin
            bad++;
            $display("FAIL async_drop got=%h want=%h", obs(), lit(0, 0, 0, 0));
        end
        #1 rst_n = 1'b1;
        model_reset();
        drive(2'b10, 2'b10);
        total++;
        if (obs() !== lit(1, 0, 0, 0)) begin
            bad++;
            $display("FAIL fresh_eval got=%h want=%h", obs(), lit(1, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        logic [1:0] ca, cb;
        for (int i = 0; i < 400; i++) begin
            ca = 2'($urandom_range(0, 2));
            cb = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 39) == 0) ca = 2'b11;
            if (i == 200) pulse_reset();
            drive(ca, cb);
            total++;
            if (obs() !== mexp()) begin
                bad++;
                $display("FAIL random[%0d] a=%b b=%b got=%h want=%h",
                         i, ca, cb, obs(), mexp());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        {a1, a0, b1, b0} = 4'b0000;
        model_reset();
        test_reset();
        test_handshake();
        test_partial_null();
        test_waves();
        test_illegal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
